// File: rtl/rt_ibex_pcs_restore_wb.sv
// Interrupt-context restore write-back: captures a context popped from the LIFO and
// drains the selected slots into the register file through its single shared write port.
module rt_ibex_pcs_restore_wb #(
   parameter int unsigned NrSavedRegs  = 9,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned RegAddrWidth = 5,
   parameter logic [NrSavedRegs-1:0][RegAddrWidth-1:0] SavedRegAddrs =
      {5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd7, 5'd6, 5'd5, 5'd1}
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  restore_en_i,
   input  logic [NrSavedRegs-1:0][DataWidth-1:0] restore_data_i,
   input  logic [NrSavedRegs-1:0]                restore_mask_i,
   output logic                                  rf_we_o,
   output logic [RegAddrWidth-1:0]               rf_waddr_o,
   output logic [DataWidth-1:0]                  rf_wdata_o,
   input  logic                                  rf_wgnt_i,
   output logic                                  busy_o,
   output logic                                  irq_block_o,
   output logic                                  done_o,
   output logic                                  ovf_o
);

   localparam int unsigned IdxW = (NrSavedRegs > 1) ? $clog2(NrSavedRegs) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Slots mapped to x0 can never be written, whatever mask is supplied.
   function automatic logic [NrSavedRegs-1:0] f_nz_slots();
      logic [NrSavedRegs-1:0] m;
      m = '0;
      for (int i = 0; i < NrSavedRegs; i++) begin
         m[i] = (SavedRegAddrs[i] != '0);
      end
      return m;
   endfunction

   function automatic logic [IdxW-1:0] f_ffs(input logic [NrSavedRegs-1:0] m);
      logic [IdxW-1:0] idx;
      idx = '0;
      for (int i = NrSavedRegs - 1; i >= 0; i--) begin
         if (m[i]) idx = IdxW'(i);
      end
      return idx;
   endfunction

   localparam logic [NrSavedRegs-1:0] NzSlots = f_nz_slots();

   state_e                                r_state;
   state_e                                w_state_nxt;
   logic [NrSavedRegs-1:0][DataWidth-1:0] r_buf;
   logic [NrSavedRegs-1:0]                r_mask;
   logic                                  r_ovf;

   logic [NrSavedRegs-1:0] w_eff_mask;
   logic [IdxW-1:0]        w_idx;
   logic [NrSavedRegs-1:0] w_onehot;
   logic [NrSavedRegs-1:0] w_mask_left;
   logic                   w_accept;
   logic                   w_fire;

   assign w_eff_mask  = restore_mask_i & NzSlots;
   assign w_idx       = f_ffs(r_mask);
   assign w_onehot    = NrSavedRegs'(1) << w_idx;
   assign w_mask_left = r_mask & ~w_onehot;
   assign w_accept    = restore_en_i && (r_state != WRITE);
   assign w_fire      = (r_state == WRITE) && rf_wgnt_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_buf   <= '0;
         r_mask  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_buf  <= restore_data_i;
            r_mask <= w_eff_mask;
         end else if (w_fire) begin
            r_mask <= w_mask_left;
         end
         // A second context arriving mid-drain is dropped; flag it permanently.
         if (restore_en_i && (r_state == WRITE)) begin
            r_ovf <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      rf_we_o     = 1'b0;
      rf_waddr_o  = '0;
      rf_wdata_o  = '0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      unique case (r_state)
         IDLE, DONE: begin
            done_o = (r_state == DONE);
            if (restore_en_i) begin
               w_state_nxt = (w_eff_mask != '0) ? WRITE : DONE;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         WRITE: begin
            rf_we_o    = 1'b1;
            rf_waddr_o = SavedRegAddrs[w_idx];
            rf_wdata_o = r_buf[w_idx];
            busy_o     = 1'b1;
            if (rf_wgnt_i && (w_mask_left == '0)) begin
               w_state_nxt = DONE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign irq_block_o = busy_o;
   assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_rt_ibex_pcs_restore_wb.sv
// Directed bench for rt_ibex_pcs_restore_wb: full, sparse, stalled, empty, overflow,
// back-to-back and mid-sequence reset restores against hand-computed write sequences.
module tb_rt_ibex_pcs_restore_wb;

   localparam int N  = 9;
   localparam int DW = 32;
   localparam int AW = 5;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b0;
   logic              restore_en_i = 1'b0;
   logic [N-1:0][DW-1:0] restore_data_i = '0;
   logic [N-1:0]      restore_mask_i = '0;
   logic              rf_we_o;
   logic [AW-1:0]     rf_waddr_o;
   logic [DW-1:0]     rf_wdata_o;
   logic              rf_wgnt_i = 1'b1;
   logic              busy_o;
   logic              irq_block_o;
   logic              done_o;
   logic              ovf_o;

   int n_tests = 0;
   int n_fail  = 0;

   int unsigned addrs [N] = '{1, 5, 6, 7, 10, 11, 12, 13, 14};
   logic [N-1:0][DW-1:0] data_a;
   logic [N-1:0][DW-1:0] data_b;

   rt_ibex_pcs_restore_wb dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .restore_en_i   (restore_en_i),
      .restore_data_i (restore_data_i),
      .restore_mask_i (restore_mask_i),
      .rf_we_o        (rf_we_o),
      .rf_waddr_o     (rf_waddr_o),
      .rf_wdata_o     (rf_wdata_o),
      .rf_wgnt_i      (rf_wgnt_i),
      .busy_o         (busy_o),
      .irq_block_o    (irq_block_o),
      .done_o         (done_o),
      .ovf_o          (ovf_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_wr(input string tag, input int unsigned addr, input logic [DW-1:0] data);
      chk({tag, ".we"},    64'(rf_we_o),     64'd1);
      chk({tag, ".addr"},  64'(rf_waddr_o),  64'(addr));
      chk({tag, ".data"},  64'(rf_wdata_o),  64'(data));
      chk({tag, ".busy"},  64'(busy_o),      64'd1);
      chk({tag, ".irqb"},  64'(irq_block_o), 64'd1);
      chk({tag, ".done"},  64'(done_o),      64'd0);
   endtask

   task automatic chk_quiet(input string tag, input logic done_exp);
      chk({tag, ".we"},    64'(rf_we_o),     64'd0);
      chk({tag, ".addr"},  64'(rf_waddr_o),  64'd0);
      chk({tag, ".data"},  64'(rf_wdata_o),  64'd0);
      chk({tag, ".busy"},  64'(busy_o),      64'd0);
      chk({tag, ".irqb"},  64'(irq_block_o), 64'd0);
      chk({tag, ".done"},  64'(done_o),      64'(done_exp));
   endtask

   // Pulse restore_en_i in cycle T with the given mask/data; returns in cycle T+1.
   task automatic start(input logic [N-1:0] m, input logic [N-1:0][DW-1:0] d);
      tick();
      restore_en_i   = 1'b1;
      restore_mask_i = m;
      restore_data_i = d;
      tick();
      restore_en_i   = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         data_a[i] = 32'hA000_0000 + DW'(i);
         data_b[i] = 32'hB000_0000 + DW'(i);
      end

      // Reset state
      #2;
      chk_quiet("rst", 1'b0);
      chk("rst.ovf", 64'(ovf_o), 64'd0);
      tick();
      tick();
      rst_ni = 1'b1;
      tick();
      chk_quiet("idle", 1'b0);

      // Full restore, grant always high
      start(9'h1FF, data_a);
      for (int i = 0; i < N; i++) begin
         chk_wr($sformatf("full%0d", i), addrs[i], data_a[i]);
         tick();
      end
      chk_quiet("full.done", 1'b1);
      tick();
      chk_quiet("full.idle", 1'b0);

      // Sparse mask, then back-to-back pulse in the DONE cycle
      start(9'h105, data_a);
      chk_wr("sp.x1", 1, data_a[0]);
      tick();
      chk_wr("sp.x6", 6, data_a[2]);
      tick();
      chk_wr("sp.x14", 14, data_a[8]);
      tick();
      chk_quiet("sp.done", 1'b1);
      restore_en_i   = 1'b1;
      restore_mask_i = 9'h003;
      restore_data_i = data_b;
      tick();
      restore_en_i = 1'b0;
      chk_wr("b2b.x1", 1, data_b[0]);
      tick();
      chk_wr("b2b.x5", 5, data_b[1]);
      tick();
      chk_quiet("b2b.done", 1'b1);
      chk("b2b.ovf", 64'(ovf_o), 64'd0);

      // Grant stall: grant low T+1..T+3
      rf_wgnt_i = 1'b0;
      start(9'h003, data_a);
      chk_wr("st.t1", 1, data_a[0]);
      tick();
      chk_wr("st.t2", 1, data_a[0]);
      tick();
      chk_wr("st.t3", 1, data_a[0]);
      tick();
      rf_wgnt_i = 1'b1;
      chk_wr("st.t4", 1, data_a[0]);
      tick();
      chk_wr("st.t5", 5, data_a[1]);
      tick();
      chk_quiet("st.done", 1'b1);

      // Empty mask
      start(9'h000, data_a);
      chk_quiet("emp.done", 1'b1);
      tick();
      chk_quiet("emp.idle", 1'b0);

      // Overflow: second pulse at T+2 is ignored but flagged
      start(9'h1FF, data_a);
      chk_wr("ov.t1", addrs[0], data_a[0]);
      tick();
      chk_wr("ov.t2", addrs[1], data_a[1]);
      chk("ov.t2.ovf", 64'(ovf_o), 64'd0);
      restore_en_i   = 1'b1;
      restore_mask_i = 9'h001;
      restore_data_i = data_b;
      tick();
      restore_en_i = 1'b0;
      chk("ov.t3.ovf", 64'(ovf_o), 64'd1);
      for (int i = 2; i < N; i++) begin
         chk_wr($sformatf("ov%0d", i), addrs[i], data_a[i]);
         tick();
      end
      chk_quiet("ov.done", 1'b1);
      chk("ov.sticky", 64'(ovf_o), 64'd1);
      tick();
      chk("ov.sticky2", 64'(ovf_o), 64'd1);

      // Reset mid-sequence at T+4
      start(9'h1FF, data_a);
      for (int i = 0; i < 3; i++) begin
         chk_wr($sformatf("rm%0d", i), addrs[i], data_a[i]);
         tick();
      end
      chk_wr("rm3", addrs[3], data_a[3]);
      rst_ni = 1'b0;
      #1;
      chk_quiet("rm.async", 1'b0);
      chk("rm.ovf", 64'(ovf_o), 64'd0);
      tick();
      rst_ni = 1'b1;
      tick();
      chk_quiet("rm.idle", 1'b0);
      start(9'h1FF, data_a);
      chk_wr("rm.re.x1", 1, data_a[0]);
      tick();
      chk_wr("rm.re.x5", 5, data_a[1]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rt_ibex_pcs_restore_wb.md
# rt_ibex_pcs_restore_wb

Write-back sequencer on the consumer side of the interrupt context LIFO. When the LIFO presents a restored register context, this block captures it in one cycle. It then writes each selected register back into the core register file through the single shared write port, one register per granted cycle. It holds `busy_o` and `irq_block_o` asserted so the controller defers `mret` completion and further interrupt acknowledges until the register file is consistent.

## Interface
Parameters:
- `NrSavedRegs`, 9: number of saved registers per context.
- `DataWidth`, 32: register width.
- `RegAddrWidth`, 5: register file address width.
- `SavedRegAddrs`, {x14,x13,x12,x11,x10,x7,x6,x5,x1}: packed `[NrSavedRegs-1:0][RegAddrWidth-1:0]`.
  - Entry i is the register-file address of saved slot i.
  - Slot 0 maps to x1.

Ports (reset `rst_ni`, asynchronous, active-low; clock `clk_i`):
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `restore_en_i` in 1: one-cycle pulse; `restore_data_i` is valid in this cycle.
- `restore_data_i` in `[NrSavedRegs-1:0][DataWidth-1:0]`: restored context; slot i holds the value for `SavedRegAddrs[i]`.
- `restore_mask_i` in `NrSavedRegs`: slots to write back; sampled only with `restore_en_i`.
- `rf_we_o` out 1: write request to the register file port.
- `rf_waddr_o` out `RegAddrWidth`: write address.
- `rf_wdata_o` out `DataWidth`: write data.
- `rf_wgnt_i` in 1: port grant; the write happens when `rf_we_o & rf_wgnt_i`.
- `busy_o` out 1: write-back in progress.
- `irq_block_o` out 1: equals `busy_o`; the controller suppresses `irq_ack` while it is high.
- `done_o` out 1: one-cycle pulse after the last write.
- `ovf_o` out 1: sticky error; set when `restore_en_i` arrives while in WRITE.

## Operation
- Registered state: context buffer (`NrSavedRegs*DataWidth`), pending mask, FSM, sticky `ovf_o`.
- States: IDLE, WRITE, DONE.
- IDLE or DONE with `restore_en_i`:
  - Load the buffer from `restore_data_i`.
  - Load the pending mask from `restore_mask_i`, with slots whose `SavedRegAddrs` entry is 0 forced to 0 (x0 is never written).
  - Next state is WRITE if the effective mask is nonzero, else DONE.
- IDLE or DONE without `restore_en_i`: go to IDLE.
- WRITE outputs:
  - idx is the lowest set bit of the pending mask.
  - `rf_we_o`=1, `rf_waddr_o`=`SavedRegAddrs[idx]`, `rf_wdata_o`=buffer[idx].
- WRITE transitions:
  - On `rf_wgnt_i`: clear pending bit idx. If no bits remain, go to DONE; otherwise stay in WRITE with the next idx shown in the following cycle.
  - Without grant: hold address and data stable, `rf_we_o` stays high.
- DONE: `done_o`=1 for exactly that cycle.
- Masked slots cost zero cycles; the find-first-set skips them.
- `restore_en_i` while in WRITE:
  - Ignored: buffer and mask are unchanged and the write sequence continues.
  - `ovf_o` is set and stays set until reset.
- Outputs are combinational from registered state only; no combinational path exists from `restore_en_i` to any output. `rf_waddr_o`/`rf_wdata_o` are 0 when `rf_we_o`=0.

## Timing
- Reset values:
  - All outputs 0; state IDLE; buffer and mask 0.
  - `ovf_o` is cleared only by reset.
  - Reset asserted mid-WRITE aborts immediately; no further `rf_we_o`.
- Pulse at cycle T with k effective bits and grant always high:
  - `rf_we_o` is high in T+1..T+k.
  - `done_o` at T+k+1.
  - `busy_o` is high in T+1..T+k and low in DONE.
- k=0: `done_o` at T+1; no write and no busy.
- Each grant-low cycle extends the sequence by one cycle.
- Back-to-back: a `restore_en_i` coinciding with `done_o` is accepted without loss and without `ovf_o`.

## Test plan
- Full restore: mask 0x1FF, data slot i = 0xA000_0000+i, grant=1.
  - Nine writes, to x1,x5,x6,x7,x10..x14, with matching data in consecutive cycles T+1..T+9.
  - `done_o` at T+10.
- Sparse mask 0x105: writes x1 (T+1), x6 (T+2), x14 (T+3); `done_o` at T+4.
- Grant stall: mask 0x003, grant low in T+1..T+3.
  - x1 is held stable until grant; x1 completes at T+4, x5 at T+5.
  - `busy_o` is high T+1..T+5.
- Empty mask: mask 0x000 gives `done_o` at T+1, `rf_we_o` never high, `busy_o` never high.
- Overflow: second `restore_en_i` at T+2 of a 0x1FF sequence.
  - Original data is still written and all nine writes complete.
  - `ovf_o` goes high at T+3 and stays high.
- Reset mid-op: assert `rst_ni` low at T+4 of a 0x1FF sequence.
  - All outputs read 0 immediately and state is IDLE after release.
  - A new pulse restarts cleanly at x1.
